// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC register, redirect target select, IF/ID pipeline register
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   Stall                hold PC and IF/ID (ignores Branch)
//   Branch               redirect request for the instruction in ID
//   Jump, JumpR          redirect target qualifiers (J-type index / register)
//   IdPc4, IdInstr, IdRs ID-stage PC+4, instruction word and forwarded rs
//   ImemAddr, ImemData   combinational instruction memory lookup
//   IfIdInstr, IfIdPc4   registered fetch result to ID
//   IfIdValid            low when IF/ID carries a bubble
//   AddrErr              sticky misaligned-redirect flag
//   RedirectCnt          saturating count of taken redirects
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        JumpR,
    input  logic [31:0] IdPc4,
    input  logic [31:0] IdInstr,
    input  logic [31:0] IdRs,
    output logic [31:0] ImemAddr,
    input  logic [31:0] ImemData,
    output logic [31:0] IfIdInstr,
    output logic [31:0] IfIdPc4,
    output logic        IfIdValid,
    output logic        AddrErr,
    output logic [15:0] RedirectCnt
);

    // Per-cycle flow: RUN advances fetch (a redirect is a RUN cycle with a
    // flush), HOLD freezes everything. The flow is a pure function of Stall.
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc4;
    logic        r_ifid_valid;
    logic        r_addr_err;
    logic [15:0] r_redirect_cnt;

    logic [0:0]  w_flow;
    logic        w_redirect;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_offset;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_target;
    logic        w_unused_opcode;

    assign w_flow     = Stall ? ST_HOLD : ST_RUN;
    assign w_redirect = (w_flow == ST_RUN) && Branch;
    assign w_pc_plus4 = r_pc + 32'd4;

    // Branch offset: sign-extended 16-bit word offset, scaled to bytes.
    assign w_br_offset = {{14{IdInstr[15]}}, IdInstr[15:0], 2'b00};
    assign w_br_target = IdPc4 + w_br_offset;
    assign w_j_target  = {IdPc4[31:28], IdInstr[25:0], 2'b00};

    always_comb begin
        w_target = w_br_target;
        if (JumpR) begin
            w_target = IdRs;
        end else if (Jump) begin
            w_target = w_j_target;
        end
    end

    // Opcode bits are decoded elsewhere; they do not affect fetch.
    assign w_unused_opcode = ^IdInstr[31:26];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc           <= RESET_PC;
            r_ifid_instr   <= 32'h0;
            r_ifid_pc4     <= 32'h0;
            r_ifid_valid   <= 1'b0;
            r_addr_err     <= 1'b0;
            r_redirect_cnt <= 16'h0;
        end else if (w_flow == ST_RUN) begin
            if (w_redirect) begin
                // Flush the wrong-path fetch; no delay slot.
                r_pc         <= {w_target[31:2], 2'b00};
                r_ifid_instr <= 32'h0;
                r_ifid_pc4   <= 32'h0;
                r_ifid_valid <= 1'b0;
                if (w_target[1:0] != 2'b00) begin
                    r_addr_err <= 1'b1;
                end
                if (r_redirect_cnt != 16'hFFFF) begin
                    r_redirect_cnt <= r_redirect_cnt + 16'd1;
                end
            end else begin
                r_pc         <= w_pc_plus4;
                r_ifid_instr <= ImemData;
                r_ifid_pc4   <= w_pc_plus4;
                r_ifid_valid <= 1'b1;
            end
        end
    end

    assign ImemAddr    = r_pc;
    assign IfIdInstr   = r_ifid_instr;
    assign IfIdPc4     = r_ifid_pc4;
    assign IfIdValid   = r_ifid_valid;
    assign AddrErr     = r_addr_err;
    assign RedirectCnt = r_redirect_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Stall = 1'b0;
    logic        Branch = 1'b0;
    logic        Jump = 1'b0;
    logic        JumpR = 1'b0;
    logic [31:0] IdPc4 = 32'h0;
    logic [31:0] IdInstr = 32'h0;
    logic [31:0] IdRs = 32'h0;
    logic [31:0] ImemAddr;
    logic [31:0] ImemData;
    logic [31:0] IfIdInstr;
    logic [31:0] IfIdPc4;
    logic        IfIdValid;
    logic        AddrErr;
    logic [15:0] RedirectCnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_err;
    int          m_cnt;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .Stall(Stall), .Branch(Branch), .Jump(Jump),
        .JumpR(JumpR), .IdPc4(IdPc4), .IdInstr(IdInstr), .IdRs(IdRs),
        .ImemAddr(ImemAddr), .ImemData(ImemData), .IfIdInstr(IfIdInstr),
        .IfIdPc4(IfIdPc4), .IfIdValid(IfIdValid), .AddrErr(AddrErr),
        .RedirectCnt(RedirectCnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign ImemData = imem_word(ImemAddr);

    function automatic logic [31:0] ref_target(input logic j, input logic jr,
                                               input logic [31:0] pc4,
                                               input logic [31:0] instr,
                                               input logic [31:0] rs);
        logic signed [31:0] off;
        logic [25:0] idx;
        if (jr) return rs;
        if (j) begin
            idx = instr[25:0];
            return (pc4 & 32'hF000_0000) | (32'(idx) * 4);
        end
        off = $signed(instr[15:0]);
        return pc4 + off * 4;
    endfunction

    // Advance the reference by one cycle from the current inputs, then clock the DUT.
    task automatic tick();
        logic [31:0] t;
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
            m_valid = 1'b0; m_err = 1'b0; m_cnt = 0;
        end else if (!Stall) begin
            if (Branch) begin
                t = ref_target(Jump, JumpR, IdPc4, IdInstr, IdRs);
                if (t % 4 != 0) m_err = 1'b1;
                m_pc = t - (t % 4);
                m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end else begin
                m_instr = imem_word(m_pc);
                m_pc4 = m_pc + 32'd4;
                m_valid = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; Stall = 1'b0; Branch = 1'b0; Jump = 1'b0; JumpR = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; Stall = 1'b1; Branch = 1'b1;
        tick();
        n_cmp++; if (ImemAddr !== 32'h0) begin n_err++; $display("FAIL reset_pc act=%h exp=%h", ImemAddr, 32'h0); end
        n_cmp++; if (IfIdInstr !== 32'h0) begin n_err++; $display("FAIL reset_instr act=%h exp=%h", IfIdInstr, 32'h0); end
        n_cmp++; if (IfIdPc4 !== 32'h0) begin n_err++; $display("FAIL reset_pc4 act=%h exp=%h", IfIdPc4, 32'h0); end
        n_cmp++; if (IfIdValid !== 1'b0) begin n_err++; $display("FAIL reset_valid act=%b exp=0", IfIdValid); end
        n_cmp++; if (AddrErr !== 1'b0) begin n_err++; $display("FAIL reset_err act=%b exp=0", AddrErr); end
        n_cmp++; if (RedirectCnt !== 16'h0) begin n_err++; $display("FAIL reset_cnt act=%h exp=0", RedirectCnt); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            exp_addr = 32'(i * 4);
            n_cmp++; if (ImemAddr !== exp_addr) begin n_err++; $display("FAIL seq_addr%0d act=%h exp=%h", i, ImemAddr, exp_addr); end
            tick();
            n_cmp++; if (IfIdPc4 !== exp_addr + 32'd4) begin n_err++; $display("FAIL seq_pc4%0d act=%h exp=%h", i, IfIdPc4, exp_addr + 32'd4); end
            n_cmp++; if (IfIdInstr !== imem_word(exp_addr)) begin n_err++; $display("FAIL seq_instr%0d act=%h exp=%h", i, IfIdInstr, imem_word(exp_addr)); end
            n_cmp++; if (IfIdValid !== 1'b1) begin n_err++; $display("FAIL seq_valid%0d act=%b exp=1", i, IfIdValid); end
        end
    endtask

    task automatic test_branch();
        Branch = 1'b1; IdPc4 = 32'h0000_0010; IdInstr = 32'h0000_FFFE;
        tick();
        idle_inputs();
        n_cmp++; if (ImemAddr !== 32'h0000_0008) begin n_err++; $display("FAIL branch_pc act=%h exp=%h", ImemAddr, 32'h8); end
        n_cmp++; if (IfIdValid !== 1'b0 || IfIdInstr !== 32'h0 || IfIdPc4 !== 32'h0) begin
            n_err++; $display("FAIL branch_bubble act=%b/%h/%h exp=0/0/0", IfIdValid, IfIdInstr, IfIdPc4); end
        n_cmp++; if (RedirectCnt !== 16'd1) begin n_err++; $display("FAIL branch_cnt act=%0d exp=1", RedirectCnt); end
    endtask

    task automatic test_jump();
        Branch = 1'b1; Jump = 1'b1; IdPc4 = 32'hA000_0004; IdInstr = 32'h0000_0100;
        tick();
        n_cmp++; if (ImemAddr !== 32'hA000_0400) begin n_err++; $display("FAIL jump_pc act=%h exp=%h", ImemAddr, 32'hA000_0400); end
        n_cmp++; if (AddrErr !== 1'b0) begin n_err++; $display("FAIL jump_err act=%b exp=0", AddrErr); end
        Jump = 1'b0; JumpR = 1'b1; IdRs = 32'h0000_1002;
        tick();
        idle_inputs();
        n_cmp++; if (ImemAddr !== 32'h0000_1000) begin n_err++; $display("FAIL jr_pc act=%h exp=%h", ImemAddr, 32'h1000); end
        n_cmp++; if (AddrErr !== 1'b1) begin n_err++; $display("FAIL jr_err act=%b exp=1", AddrErr); end
        n_cmp++; if (RedirectCnt !== 16'd3) begin n_err++; $display("FAIL jr_cnt act=%0d exp=3", RedirectCnt); end
        n_cmp++; if (IfIdValid !== 1'b0) begin n_err++; $display("FAIL jr_bubble act=%b exp=0", IfIdValid); end
    endtask

    task automatic test_jump_no_branch();
        Jump = 1'b1; JumpR = 1'b1; IdRs = 32'h0000_8000;
        tick();
        idle_inputs();
        n_cmp++; if (ImemAddr !== 32'h0000_1004) begin n_err++; $display("FAIL nobr_pc act=%h exp=%h", ImemAddr, 32'h1004); end
        n_cmp++; if (RedirectCnt !== 16'd3) begin n_err++; $display("FAIL nobr_cnt act=%0d exp=3", RedirectCnt); end
        n_cmp++; if (AddrErr !== 1'b1) begin n_err++; $display("FAIL nobr_err_sticky act=%b exp=1", AddrErr); end
    endtask

    task automatic test_stall();
        logic [31:0] pc0, instr0, pc40;
        logic [15:0] cnt0;
        pc0 = ImemAddr; instr0 = IfIdInstr; pc40 = IfIdPc4; cnt0 = RedirectCnt;
        Stall = 1'b1; Branch = 1'b1; JumpR = 1'b1; IdRs = 32'h0000_4000;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (ImemAddr !== pc0) begin n_err++; $display("FAIL stall_pc%0d act=%h exp=%h", i, ImemAddr, pc0); end
            n_cmp++; if (IfIdInstr !== instr0 || IfIdPc4 !== pc40) begin
                n_err++; $display("FAIL stall_ifid%0d act=%h/%h exp=%h/%h", i, IfIdInstr, IfIdPc4, instr0, pc40); end
            n_cmp++; if (RedirectCnt !== cnt0) begin n_err++; $display("FAIL stall_cnt%0d act=%0d exp=%0d", i, RedirectCnt, cnt0); end
        end
        idle_inputs();
        tick();
        n_cmp++; if (ImemAddr !== pc0 + 32'd4) begin n_err++; $display("FAIL resume_pc act=%h exp=%h", ImemAddr, pc0 + 32'd4); end
        n_cmp++; if (IfIdInstr !== imem_word(pc0) || IfIdValid !== 1'b1) begin
            n_err++; $display("FAIL resume_ifid act=%h/%b exp=%h/1", IfIdInstr, IfIdValid, imem_word(pc0)); end
    endtask

    task automatic test_wrap();
        Branch = 1'b1; JumpR = 1'b1; IdRs = 32'hFFFF_FFFC;
        tick();
        idle_inputs();
        n_cmp++; if (ImemAddr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_setup act=%h exp=%h", ImemAddr, 32'hFFFF_FFFC); end
        tick();
        n_cmp++; if (ImemAddr !== 32'h0) begin n_err++; $display("FAIL wrap_pc act=%h exp=0", ImemAddr); end
        n_cmp++; if (IfIdPc4 !== 32'h0 || IfIdValid !== 1'b1) begin
            n_err++; $display("FAIL wrap_pc4 act=%h/%b exp=0/1", IfIdPc4, IfIdValid); end
    endtask

    task automatic test_reset_mid_stall();
        Stall = 1'b1; Branch = 1'b1; JumpR = 1'b1; IdRs = 32'h0000_0033;
        tick();
        rst = 1'b1;
        tick();
        n_cmp++; if (ImemAddr !== 32'h0) begin n_err++; $display("FAIL rststall_pc act=%h exp=0", ImemAddr); end
        n_cmp++; if (IfIdValid !== 1'b0 || IfIdInstr !== 32'h0 || IfIdPc4 !== 32'h0) begin
            n_err++; $display("FAIL rststall_ifid act=%b/%h/%h exp=0/0/0", IfIdValid, IfIdInstr, IfIdPc4); end
        n_cmp++; if (AddrErr !== 1'b0 || RedirectCnt !== 16'h0) begin
            n_err++; $display("FAIL rststall_flags act=%b/%0d exp=0/0", AddrErr, RedirectCnt); end
        idle_inputs();
        tick();
        n_cmp++; if (IfIdPc4 !== 32'h4 || IfIdInstr !== imem_word(32'h0)) begin
            n_err++; $display("FAIL rststall_first act=%h/%h exp=%h/%h", IfIdPc4, IfIdInstr, 32'h4, imem_word(32'h0)); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 39) == 0);
            Stall  = ($urandom_range(0, 3) == 0);
            Branch = ($urandom_range(0, 2) == 0);
            Jump   = $urandom_range(0, 1);
            JumpR  = $urandom_range(0, 1);
            IdPc4  = $urandom;
            IdInstr = $urandom;
            IdRs   = ($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
            tick();
            n_cmp++;
            if (ImemAddr !== m_pc || IfIdInstr !== m_instr || IfIdPc4 !== m_pc4 ||
                IfIdValid !== m_valid || AddrErr !== m_err || RedirectCnt !== 16'(m_cnt)) begin
                n_err++;
                $display("FAIL rand%0d act=%h/%h/%h/%b/%b/%0d exp=%h/%h/%h/%b/%b/%0d", i,
                         ImemAddr, IfIdInstr, IfIdPc4, IfIdValid, AddrErr, RedirectCnt,
                         m_pc, m_instr, m_pc4, m_valid, m_err, m_cnt);
            end
        end
        idle_inputs();
    endtask

    initial begin
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_err = 1'b0; m_cnt = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_jump_no_branch();
        test_stall();
        test_wrap();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000; PC value loaded on reset.
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: Stall  in  1  hazard hold; freezes PC and IF/ID register.
REQ-005 Port: Branch  in  1  redirect request from branch unit, for the instruction now in ID.
REQ-006 Port: Jump  in  1  J-type redirect qualifier.
REQ-007 Port: JumpR  in  1  register-jump redirect qualifier.
REQ-008 Port: IdPc4  in  32  PC+4 of the instruction in ID.
REQ-009 Port: IdInstr  in  32  instruction in ID; imm = [15:0], index = [25:0].
REQ-010 Port: IdRs  in  32  forwarded rs operand, the jr target.
REQ-011 Port: ImemAddr  out  32  current PC to the combinational instruction memory.
REQ-012 Port: ImemData  in  32  instruction at ImemAddr, same cycle.
REQ-013 Port: IfIdInstr  out  32  registered instruction to ID.
REQ-014 Port: IfIdPc4  out  32  registered PC+4 to ID.
REQ-015 Port: IfIdValid  out  1  high when IfIdInstr is a real fetch, not a bubble.
REQ-016 Port: AddrErr  out  1  sticky flag, misaligned redirect target.
REQ-017 Port: RedirectCnt  out  16  count of taken redirects, saturating.

Function
REQ-018 ImemAddr SHALL equal the PC register; no added latency. Fetch-to-ID latency is one cycle.
REQ-019 Target selection, in priority order:
- JumpR=1: IdRs.
- else Jump=1: {IdPc4[31:28], IdInstr[25:0], 2'b00}.
- else: IdPc4 + (sign-extend(IdInstr[15:0]) << 2), modulo 2^32, wrap-around allowed.
REQ-020 Redirect SHALL be Branch=1 and Stall=0. Jump or JumpR without Branch SHALL be ignored.
REQ-021 Stall=1 SHALL take priority over everything except rst:
- PC, IfIdInstr, IfIdPc4, IfIdValid, AddrErr and RedirectCnt hold.
- Branch is ignored.
REQ-022 On a redirect:
- PC <= target with bits [1:0] forced to 0.
- IF/ID loads a bubble: IfIdInstr=32'h0, IfIdPc4=32'h0, IfIdValid=0.
- The wrong-path fetch is discarded. There is no delay slot.
REQ-023 When there is no stall and no redirect:
- PC <= PC+4, modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0.
- IfIdInstr <= ImemData, IfIdPc4 <= PC+4, IfIdValid <= 1.
REQ-024 AddrErr SHALL set on a redirect whose target[1:0] != 0, and stay set until rst.
REQ-025 RedirectCnt SHALL increment by 1 per redirect and saturate at 16'hFFFF.
REQ-026 Back-to-back redirects SHALL each flush and each count. A bubble in ID decodes as a non-branch, so no self-redirect occurs.
REQ-027 The block SHALL act as a two-state flow per cycle: RUN (fetch advances) or HOLD (Stall). A redirect is a RUN cycle with a flush; there is no extra state.

Reset
REQ-028 rst SHALL override Stall and Branch, and SHALL take effect at the next rising edge:
- PC=RESET_PC.
- IfIdInstr=32'h0, IfIdPc4=32'h0, IfIdValid=0.
- AddrErr=0, RedirectCnt=0.
REQ-029 rst asserted mid-stall or mid-redirect SHALL discard the pending operation. The first fetch after release SHALL be at RESET_PC.

Verification
REQ-030 Set RESET_PC=0, rst for 1 cycle, then run 3 cycles with no stall or branch. ImemAddr SHALL go 0, 4, 8. IfIdPc4 SHALL go 4, 8, 12 with IfIdValid=1.
REQ-031 Take a branch: IdPc4=32'h0000_0010, imm=16'hFFFE, Branch=1. Next PC SHALL be 32'h0000_0008, IF/ID SHALL hold a bubble, RedirectCnt SHALL be 1.
REQ-032 Take jumps:
- Jump=1, Branch=1, IdPc4=32'hA000_0004, index=26'h0000100: next PC SHALL be 32'hA000_0400.
- Then JumpR=1, Branch=1, IdRs=32'h0000_1002: next PC SHALL be 32'h0000_1000 with AddrErr=1.
REQ-033 Assert Stall=1 together with Branch=1 for 2 cycles. PC, IF/ID and RedirectCnt SHALL be unchanged. With Stall=0 and Branch=0 the next cycle, sequential fetch SHALL resume.
REQ-034 Wrap and reset:
- With PC=32'hFFFF_FFFC and no redirect, next PC SHALL be 32'h0.
- Assert rst with Stall=1: PC SHALL become RESET_PC and all flags SHALL clear.
